// File: rtl/tdc_hit_collector.sv
// Multi-hit TDC collector: timestamps SPAD hits within a start-triggered frame,
// buffers up to MAX_HITS of them and drains the frame as a valid/ready stream.
module tdc_hit_collector #(
  parameter int DATA_W   = 15,
  parameter int FINE_W   = 4,
  parameter int N_SPAD   = 16,
  parameter int INT_W    = 5,
  parameter int MAX_HITS = 4,
  parameter int NUM_W    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              hit_i,
  input  logic [FINE_W-1:0] hit_fine_i,
  input  logic [N_SPAD-1:0] hit_spaden_i,
  input  logic [DATA_W-1:0] range_i,
  output logic [DATA_W-1:0] odata,
  output logic [INT_W-1:0]  oint,
  output logic [NUM_W-1:0]  onum,
  output logic              olast,
  output logic              ovalid,
  input  logic              oready,
  output logic              int_o,
  output logic              busy_o
);
  localparam int CW    = DATA_W - FINE_W;
  localparam int CNT_W = $clog2(MAX_HITS + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACQ   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_IRQ   = 2'd3;

  typedef struct packed {
    logic [DATA_W-1:0] ts;
    logic [INT_W-1:0]  pc;
  } hit_t;

  logic [1:0]        state;
  logic              start_q;
  logic [CW-1:0]     coarse;
  logic [DATA_W-1:0] rng;
  logic [CNT_W-1:0]  cnt;
  logic [NUM_W-1:0]  rd_idx;
  hit_t              hbuf [MAX_HITS];

  function automatic logic [INT_W-1:0] popcnt(input logic [N_SPAD-1:0] m);
    logic [INT_W-1:0] s;
    s = '0;
    for (int i = 0; i < N_SPAD; i++) s = s + INT_W'(m[i]);
    return s;
  endfunction

  logic [DATA_W-1:0] ts;
  logic [INT_W-1:0]  pc;
  logic              accept, acq_done, empty, last_beat, xfer;

  assign ts        = {coarse, hit_fine_i};
  assign pc        = popcnt(hit_spaden_i);
  assign accept    = (state == S_ACQ) && hit_i && (pc != '0) && (ts < rng)
                     && (cnt != CNT_W'(MAX_HITS));
  // Range end and buffer-full both close the frame; the hit in that cycle still counts.
  assign acq_done  = (coarse == rng[DATA_W-1:FINE_W])
                     || (accept && cnt == CNT_W'(MAX_HITS - 1));
  assign empty     = (cnt == '0);
  assign last_beat = empty || (CNT_W'(rd_idx) == cnt - 1'b1);
  assign xfer      = ovalid && oready;

  // Stream outputs are a pure mux of registered state, so they hold while stalled.
  assign ovalid = (state == S_DRAIN);
  assign odata  = !ovalid ? '0 : empty ? '1 : hbuf[rd_idx].ts;
  assign oint   = (!ovalid || empty) ? '0 : hbuf[rd_idx].pc;
  assign onum   = (!ovalid || empty) ? '0 : NUM_W'(cnt - 1'b1);
  assign olast  = ovalid && last_beat;
  assign int_o  = (state == S_IRQ);
  assign busy_o = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      start_q <= 1'b0;
      coarse  <= '0;
      rng     <= '0;
      cnt     <= '0;
      rd_idx  <= '0;
      for (int i = 0; i < MAX_HITS; i++) hbuf[i] <= '0;
    end else begin
      start_q <= start_i;
      case (state)
        S_IDLE: begin
          if (start_i && !start_q) begin
            state  <= S_ACQ;
            coarse <= '0;
            rng    <= range_i;
            cnt    <= '0;
            rd_idx <= '0;
          end
        end
        S_ACQ: begin
          coarse <= coarse + 1'b1;
          if (accept) begin
            hbuf[NUM_W'(cnt)] <= '{ts: ts, pc: pc};
            cnt               <= cnt + 1'b1;
          end
          if (acq_done) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (xfer) begin
            if (last_beat) state  <= S_IRQ;
            else           rd_idx <= rd_idx + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tdc_hit_collector.sv
// Scoreboard bench for tdc_hit_collector: a frame model predicts accepted hits,
// a negedge monitor pops and compares every transferred beat.
module tb_tdc_hit_collector;
  localparam int DATA_W = 15, FINE_W = 4, N_SPAD = 16, INT_W = 5, MAX_HITS = 4, NUM_W = 2;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic              start_i = 1'b0, hit_i = 1'b0, oready = 1'b0;
  logic [FINE_W-1:0] hit_fine_i = '0;
  logic [N_SPAD-1:0] hit_spaden_i = '0;
  logic [DATA_W-1:0] range_i = '0;
  logic [DATA_W-1:0] odata;
  logic [INT_W-1:0]  oint;
  logic [NUM_W-1:0]  onum;
  logic              olast, ovalid, int_o, busy_o;

  tdc_hit_collector #(.DATA_W(DATA_W), .FINE_W(FINE_W), .N_SPAD(N_SPAD), .INT_W(INT_W),
                      .MAX_HITS(MAX_HITS), .NUM_W(NUM_W)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .hit_i(hit_i), .hit_fine_i(hit_fine_i),
    .hit_spaden_i(hit_spaden_i), .range_i(range_i), .odata(odata), .oint(oint),
    .onum(onum), .olast(olast), .ovalid(ovalid), .oready(oready), .int_o(int_o),
    .busy_o(busy_o));

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [INT_W-1:0]  i;
    logic [NUM_W-1:0]  n;
    logic              l;
  } beat_t;

  beat_t exp_q[$];
  beat_t frm_q[$];
  int checks = 0, failures = 0, n_irq = 0;
  int m_cyc = 0, m_cnt = 0;
  logic [DATA_W-1:0] m_rng = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    beat_t b;
    if (rst_n) begin
      if (int_o) n_irq++;
      if (ovalid && oready) begin
        if (exp_q.size() == 0) chk("beat_expected", 0, 1);
        else begin
          b = exp_q.pop_front();
          chk("odata", odata, b.d);
          chk("oint", oint, b.i);
          chk("onum", onum, b.n);
          chk("olast", olast, b.l);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    m_cyc++;
  endtask

  task automatic frame_start(input logic [DATA_W-1:0] r);
    range_i = r;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    m_cyc = 0; m_cnt = 0; m_rng = r;
    frm_q.delete();
    chk("busy_on_start", busy_o, 1);
  endtask

  // Drive one hit in the cycle whose coarse count is c; model decides acceptance.
  task automatic hit(input int c, input logic [FINE_W-1:0] f, input logic [N_SPAD-1:0] m);
    logic [DATA_W-1:0] t;
    beat_t b;
    while (m_cyc < c) tick();
    t = DATA_W'((c << FINE_W) | int'(f));
    hit_i = 1'b1; hit_fine_i = f; hit_spaden_i = m;
    if (m_cyc <= int'(m_rng >> FINE_W) && m_cnt < MAX_HITS && m != '0 && t < m_rng) begin
      b.d = t; b.i = INT_W'($countones(m)); b.n = '0; b.l = 1'b0;
      frm_q.push_back(b);
      m_cnt++;
    end
    tick();
    hit_i = 1'b0; hit_spaden_i = '0; hit_fine_i = '0;
  endtask

  task automatic frame_end(input int stall, input bit poke);
    int top, nb, irq0, g;
    logic [DATA_W-1:0] first;
    beat_t b;
    top = int'(m_rng >> FINE_W);
    while (m_cyc <= top && m_cnt < MAX_HITS) begin
      if (m_cyc == top) chk("acq_still_open", ovalid, 0);
      tick();
    end
    chk("drain_entry", ovalid, 1);
    nb = frm_q.size();
    for (int k = 0; k < nb; k++) begin
      b = frm_q[k];
      b.n = NUM_W'(nb - 1);
      b.l = (k == nb - 1);
      exp_q.push_back(b);
    end
    if (nb == 0) begin
      b.d = '1; b.i = '0; b.n = '0; b.l = 1'b1;
      exp_q.push_back(b);
      nb = 1;
    end
    first = exp_q[0].d;
    irq0 = n_irq;
    if (poke) start_i = 1'b1;
    repeat (stall) begin
      @(negedge clk);
      chk("stall_valid", ovalid, 1);
      chk("stall_data", odata, first);
    end
    @(posedge clk); #1;
    oready = 1'b1; start_i = 1'b0;
    repeat (nb) begin
      @(negedge clk);
      chk("no_bubble", ovalid, 1);
    end
    g = 0;
    while (busy_o && g < 50) begin tick(); g++; end
    chk("frame_done", busy_o, 0);
    oready = 1'b0;
    chk("irq_once", n_irq - irq0, 1);
    chk("scoreboard_empty", exp_q.size(), 0);
    if (poke) begin
      repeat (3) tick();
      chk("start_in_drain_ignored", busy_o, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int irq0;
    #1;
    chk("rst_ovalid", ovalid, 0);
    chk("rst_odata", odata, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_int", int_o, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Two hits, free-flowing sink
    frame_start(15'h3FC);
    hit(10, 4'h3, 16'h000F);
    hit(20, 4'h0, 16'h00FF);
    frame_end(0, 0);

    // Five eligible hits: buffer fills at the 4th
    frame_start(15'h3FC);
    hit(1, 4'h1, 16'h0001);
    hit(2, 4'h2, 16'h0003);
    hit(3, 4'h3, 16'h0007);
    hit(4, 4'h4, 16'h8001);
    chk("drain_after_4th", ovalid, 1);
    hit(5, 4'h5, 16'h0001);
    frame_end(0, 0);

    // Empty frame -> no-target marker
    frame_start(15'h3FC);
    frame_end(0, 0);

    // Backpressure on beat 0
    frame_start(15'h3FC);
    hit(10, 4'h3, 16'h000F);
    hit(20, 4'h0, 16'h00FF);
    frame_end(5, 0);

    // Range boundary, zero mask, start edge during drain
    frame_start(15'h3FC);
    hit(5, 4'h1, 16'h0000);
    hit(63, 4'hB, 16'h0003);
    frame_end(3, 1);
    frame_start(15'h3FC);
    hit(63, 4'hD, 16'h0001);
    frame_end(0, 0);

    // Reset mid-drain discards the frame
    frame_start(15'h3FC);
    hit(2, 4'h1, 16'h0007);
    while (m_cyc <= 63) tick();
    chk("pre_reset_drain", ovalid, 1);
    irq0 = n_irq;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ovalid", ovalid, 0);
    chk("mid_rst_odata", odata, 0);
    chk("mid_rst_oint", oint, 0);
    chk("mid_rst_olast", olast, 0);
    chk("mid_rst_busy", busy_o, 0);
    frm_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) tick();
    chk("no_irq_after_reset", n_irq - irq0, 0);
    chk("idle_after_reset", busy_o, 0);
    frame_start(15'h3FC);
    frame_end(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tdc_hit_collector.md
Name: tdc_hit_collector

Overview:
Parametrised multi-hit successor to the single-shot TDC result path. It opens an acquisition frame on a rising edge of the start input and timestamps SPAD hits as {coarse cycle count, fine code}. Each accepted hit also carries an intensity equal to the popcount of the active-SPAD mask. Hits are rejected at or beyond a programmable range, at most MAX_HITS are buffered per frame, and the frame is drained on a valid/ready stream with last/num tags, then an interrupt pulse is raised.

Parameters:
DATA_W, 15, timestamp/output data width
FINE_W, 4, fine-code bits (LSBs of timestamp); coarse counter width = DATA_W-FINE_W
N_SPAD, 16, SPAD enable mask width
INT_W, 5, intensity width, must hold N_SPAD (clog2(N_SPAD+1))
MAX_HITS, 4, hit buffer depth per frame (>=1)
NUM_W, 2, onum width, clog2(MAX_HITS) (min 1)

Ports:
clk  in  1  logic clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
start_i  in  1  level; rising edge (registered compare) opens a frame
hit_i  in  1  one-cycle hit strobe, synchronous to clk
hit_fine_i  in  FINE_W  fine phase code valid with hit_i
hit_spaden_i  in  N_SPAD  SPADs fired for this hit
range_i  in  DATA_W  max timestamp (exclusive), sampled at frame open
odata  out  DATA_W  hit timestamp, or all-ones no-target marker
oint  out  INT_W  popcount of hit mask, 0 for the marker
onum  out  NUM_W  hits in frame minus 1, constant across the frame
olast  out  1  final beat of frame
ovalid  out  1  beat valid
oready  in  1  sink ready
int_o  out  1  one-cycle frame-done pulse
busy_o  out  1  high in any state except IDLE

Behaviour:
- Reset (async): state IDLE; all outputs 0; coarse counter, hit count, buffer and start edge register cleared. Asserting reset mid-frame or mid-drain discards the frame; no int_o is produced.
- States: IDLE -> ACQ on start rising edge. Coarse counter set to 0 and range latched in the same edge. Start edges in any other state are ignored.
- ACQ: coarse increments by 1 every cycle. Timestamp = {coarse, hit_fine_i}.
- Hit accepted iff all hold: hit_i=1, popcount(hit_spaden_i)>0, timestamp < latched range, count < MAX_HITS. Accepted hits are written to buffer[count] and count increments.
- ACQ -> DRAIN on the cycle after either of: coarse == range[DATA_W-1:FINE_W], or the accept that makes count == MAX_HITS. A hit in that same cycle is still evaluated against the accept rule.
- Hits outside ACQ are dropped.
- DRAIN: beats are emitted in arrival order. ovalid rises the first cycle in DRAIN (registered output).
- A beat transfers when ovalid and oready are both high. While ovalid=1 and oready=0, odata, oint, onum and olast hold stable.
- olast=1 only on beat index count-1. onum = count-1 for every beat.
- count==0: a single beat is emitted with odata = all-ones, oint=0, onum=0, olast=1.
- DRAIN -> IRQ on the transfer of the olast beat. ovalid drops the next cycle unless a further beat follows; there are no bubbles between beats when oready=1.
- IRQ: int_o=1 for exactly one cycle, then IDLE. busy_o is 0 from IDLE onward.
- Popcount is combinational over N_SPAD and registered with the hit.
- The coarse counter cannot wrap within a frame, because range < 2^DATA_W ends ACQ first.

Test Plan:
1. Defaults, range_i=0x3FC, start; hits at coarse 10/fine 3/mask 0x000F and coarse 20/fine 0/mask 0x00FF -> beats (0x0A3, oint 4, onum 1, olast 0), then (0x140, 8, 1, 1). ACQ ends after coarse 63, then one int_o pulse.
2. Five accepted-eligible hits at coarse 1..5 -> exactly 4 beats (coarse 1..4), onum=3, DRAIN entered the cycle after the 4th hit, and the 5th hit is dropped.
3. Start with no hits -> single beat odata 0x7FFF, oint 0, onum 0, olast 1, then int_o.
4. Scenario 1 with oready held low 5 cycles on beat 0 -> ovalid stays 1 and odata stays 0x0A3 throughout; beat 1 follows the cycle after oready=1.
5. Range boundary: at coarse 63, fine 0xB is accepted (0x3FB) and fine 0xD is rejected (0x3FD). A hit with mask 0x0000 is ignored. A start edge during DRAIN is ignored.
6. rst_n pulsed low mid-DRAIN -> all outputs 0 immediately, no int_o. A subsequent start frame behaves as in scenario 3.
